// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared macros, widths and entry type for the writeback completion queue
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef N_PHY_REG
`define N_PHY_REG 64
`endif
`ifndef CDB_BITS
`define CDB_BITS 7
`endif
`ifndef XLEN
`define XLEN 32
`endif

package wb_pkg;
  localparam int WB_DEPTH = 8;
  localparam int PTR_W    = $clog2(WB_DEPTH);
  localparam int CNT_W    = $clog2(WB_DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [`CDB_BITS-1:0] tag;
    logic [`XLEN-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_enq_alloc.sv
// rtl/wb_enq_alloc.sv - prefix-count allocator granting FU results into the free queue slots
module wb_enq_alloc
  import wb_pkg::*;
#(
  parameter int N_FU = 4
) (
  input  logic [N_FU-1:0]            fu_valid,
  input  cnt_t                       free,
  input  logic                       block,
  output logic [N_FU-1:0]            fu_ready,
  output logic [N_FU-1:0][PTR_W-1:0] offset,
  output cnt_t                       n_acc
);

  cnt_t acc;

  // acc counts grants so far; it equals the valid prefix until it saturates at free
  always_comb begin
    acc      = '0;
    fu_ready = '0;
    offset   = '0;
    for (int i = 0; i < N_FU; i++) begin
      offset[i] = acc[PTR_W-1:0];
      if (fu_valid[i] && (acc < free) && !block) begin
        fu_ready[i] = 1'b1;
        acc         = acc + cnt_t'(1);
      end
    end
    n_acc = acc;
  end

endmodule

// File: rtl/wb_complete_queue.sv
// rtl/wb_complete_queue.sv - in-order completion FIFO draining N_WAY entries per cycle to regfile/CDB
module wb_complete_queue
  import wb_pkg::*;
#(
  parameter int N_FU  = 4,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [N_FU-1:0]                     fu_valid,
  input  logic [N_FU-1:0][`CDB_BITS-1:0]      fu_tag,
  input  logic [N_FU-1:0][`XLEN-1:0]          fu_data,
  output logic [N_FU-1:0]                     fu_ready,
  input  logic                                squash,
  input  logic [$clog2(`N_PHY_REG):0]         zero_reg_pr,
  output logic [`N_WAY-1:0]                   wr_en,
  output logic [`N_WAY-1:0][`CDB_BITS-1:0]    wr_idx,
  output logic [`N_WAY-1:0][`XLEN-1:0]        wr_data,
  output logic [$clog2(DEPTH+1)-1:0]          count
);

  wb_entry_t                  mem_q [DEPTH];
  logic [DEPTH-1:0]           valid_q, valid_d;
  ptr_t                       head_q, head_d, tail_q, tail_d;
  cnt_t                       count_q, count_d;
  cnt_t                       free, n_acc, n_drain;
  logic [N_FU-1:0][PTR_W-1:0] offset;
  logic                       block;
  ptr_t                       slot;

  assign block = squash || !reset_n;
  // Free space ignores this cycle's drain so fu_ready never depends on the retire path
  assign free  = cnt_t'(DEPTH) - count_q;
  assign count = count_q;

  wb_enq_alloc #(.N_FU(N_FU)) u_alloc (
    .fu_valid (fu_valid),
    .free     (free),
    .block    (block),
    .fu_ready (fu_ready),
    .offset   (offset),
    .n_acc    (n_acc)
  );

  always_comb begin
    wr_en   = '0;
    wr_idx  = '0;
    wr_data = '0;
    n_drain = '0;
    slot    = '0;
    for (int k = 0; k < `N_WAY; k++) begin
      slot = head_q + ptr_t'(k);
      if (reset_n && (cnt_t'(k) < count_q) && valid_q[slot]) begin
        n_drain    = n_drain + cnt_t'(1);
        wr_idx[k]  = mem_q[slot].tag;
        wr_data[k] = mem_q[slot].data;
        wr_en[k]   = (mem_q[slot].tag != zero_reg_pr) && !squash;
      end
    end
  end

  always_comb begin
    head_d  = head_q + n_drain[PTR_W-1:0];
    tail_d  = tail_q + n_acc[PTR_W-1:0];
    count_d = count_q + n_acc - n_drain;
    valid_d = valid_q;
    for (int k = 0; k < `N_WAY; k++) begin
      if (cnt_t'(k) < n_drain) valid_d[head_q + ptr_t'(k)] = 1'b0;
    end
    for (int i = 0; i < N_FU; i++) begin
      if (fu_ready[i]) valid_d[tail_q + offset[i]] = 1'b1;
    end
    if (squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < N_FU; i++) begin
      if (fu_ready[i]) mem_q[tail_q + offset[i]] <= '{tag: fu_tag[i], data: fu_data[i]};
    end
  end

endmodule

// File: tb/tb_wb_complete_queue.sv
// tb/tb_wb_complete_queue.sv - randomized scoreboard bench for the writeback completion queue
module tb_wb_complete_queue;
  import wb_pkg::*;

  localparam int N_FU = 4;
  localparam int NW   = `N_WAY;
  localparam logic [`CDB_BITS-1:0] ZR = `CDB_BITS'(45);

  logic                           clock = 1'b0;
  logic                           reset_n = 1'b0;
  logic                           squash = 1'b0;
  logic [N_FU-1:0]                fu_valid = '0;
  logic [N_FU-1:0][`CDB_BITS-1:0] fu_tag = '0;
  logic [N_FU-1:0][`XLEN-1:0]     fu_data = '0;
  logic [N_FU-1:0]                fu_ready;
  logic [`CDB_BITS-1:0]           zero_reg_pr = ZR;
  logic [NW-1:0]                  wr_en;
  logic [NW-1:0][`CDB_BITS-1:0]   wr_idx;
  logic [NW-1:0][`XLEN-1:0]       wr_data;
  logic [CNT_W-1:0]               count;

  int checks = 0;
  int failures = 0;

  wb_entry_t occ_q[$];
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  wb_complete_queue #(.N_FU(N_FU), .DEPTH(WB_DEPTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fu_valid    (fu_valid),
    .fu_tag      (fu_tag),
    .fu_data     (fu_data),
    .fu_ready    (fu_ready),
    .squash      (squash),
    .zero_reg_pr (zero_reg_pr),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .count       (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h required 0x%0h", nm, $time, act, req);
    end
  endtask

  // Reference model: the queue is a list of accepted results; each cycle the two oldest leave
  always @(negedge clock) begin
    logic [NW-1:0]   ew;
    logic [N_FU-1:0] er;
    int              freec;
    int              acc;
    int              nd;
    ew = '0;
    er = '0;
    if (!reset_n) begin
      occ_q.delete();
      exp_q.delete();
    end
    if (reset_n && !squash) begin
      for (int k = 0; k < NW; k++)
        if (k < occ_q.size() && occ_q[k].tag != ZR) ew[k] = 1'b1;
      freec = WB_DEPTH - occ_q.size();
      acc = 0;
      for (int i = 0; i < N_FU; i++)
        if (fu_valid[i] && acc < freec) begin
          er[i] = 1'b1;
          acc++;
        end
    end
    chk("count", 64'(count), 64'(occ_q.size()));
    chk("wr_en", 64'(wr_en), 64'(ew));
    chk("fu_ready", 64'(fu_ready), 64'(er));
    if (count > CNT_W'(WB_DEPTH)) chk("count_bound", 64'(count), 64'(WB_DEPTH));
    if (reset_n) begin
      if (squash) begin
        occ_q.delete();
        exp_q.delete();
      end else begin
        nd = (occ_q.size() < NW) ? occ_q.size() : NW;
        for (int k = 0; k < nd; k++) void'(occ_q.pop_front());
        for (int i = 0; i < N_FU; i++)
          if (er[i]) begin
            occ_q.push_back('{tag: fu_tag[i], data: fu_data[i]});
            if (fu_tag[i] != ZR) exp_q.push_back('{tag: fu_tag[i], data: fu_data[i]});
          end
      end
    end
  end

  // Monitor: every CDB broadcast must be the next outstanding non-zero-reg result
  always @(negedge clock) begin
    for (int k = 0; k < NW; k++) begin
      if (wr_en[k]) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL cdb_unexpected slot %0d at %0t: got tag %0d required no write", k, $time, wr_idx[k]);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cdb_tag", 64'(wr_idx[k]), 64'(mon_e.tag));
          chk("cdb_data", 64'(wr_data[k]), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic rand_fu(input bit allow_zero);
    for (int i = 0; i < N_FU; i++) begin
      if (allow_zero && $urandom_range(0, 5) == 0) fu_tag[i] = ZR;
      else fu_tag[i] = `CDB_BITS'($urandom_range(0, 127));
      fu_data[i] = $urandom;
    end
  endtask

  task automatic step(input logic [N_FU-1:0] v, input logic sq);
    @(posedge clock);
    #1;
    fu_valid = v;
    squash   = sq;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step('0, 1'b0);
  endtask

  initial begin
    fu_valid = 4'hF;
    rand_fu(1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    fu_valid = '0;
    idle(3);

    fu_tag[0]  = `CDB_BITS'(3);
    fu_data[0] = `XLEN'(32'hA5);
    step(4'b0001, 1'b0);
    idle(3);

    for (int c = 0; c < 6; c++) begin
      rand_fu(1'b0);
      step(4'hF, 1'b0);
    end
    idle(5);

    fu_tag[0]  = ZR;
    fu_data[0] = $urandom;
    fu_tag[1]  = `CDB_BITS'(7);
    fu_data[1] = $urandom;
    step(4'b0011, 1'b0);
    idle(3);

    rand_fu(1'b0);
    step(4'hF, 1'b0);
    rand_fu(1'b0);
    step(4'b0111, 1'b0);
    rand_fu(1'b0);
    step(4'b0111, 1'b1);
    idle(2);
    fu_tag[0]  = `CDB_BITS'(3);
    fu_data[0] = `XLEN'(32'hA5);
    step(4'b0001, 1'b0);
    idle(3);

    for (int c = 0; c < 40; c++) begin
      rand_fu(1'b1);
      step(N_FU'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0));
    end
    idle(6);

    @(negedge clock);
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
